// File: rtl/cluster_clock_pkg.sv
// Shared types and default timing for the cluster clock switch sequencer.
// State encoding and reset-time defaults live here so the top and its users agree.
package cluster_clock_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_OFF    = 2'd1,
    WAIT_SETTLE = 2'd2
  } switch_state_t;

  localparam int unsigned DEF_GATE_WAIT_CYCLES = 4;
  localparam int unsigned DEF_SETTLE_CYCLES    = 8;
  localparam logic        DEF_RESET_SEL        = 1'b0;

endpackage

// File: rtl/cluster_clock_switch_cnt.sv
// Loadable down-counter timing the gate-off and settle windows of a clock switch.
// Load has priority over decrement; the zero flag is taken from the held count.
module cluster_clock_switch_cnt #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cluster_clock_switch_ctrl.sv
// Safe select sequencer for a 2:1 cluster clock mux: gate off, wait, flip select,
// wait for settling, gate back on, then acknowledge with a one-cycle pulse.
module cluster_clock_switch_ctrl
  import cluster_clock_pkg::*;
#(
  parameter int unsigned GATE_WAIT_CYCLES = DEF_GATE_WAIT_CYCLES,
  parameter int unsigned SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter logic        RESET_SEL        = DEF_RESET_SEL
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic sel_target_i,
  input  logic test_mode_i,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic ack_o,
  output logic busy_o
);

  localparam int unsigned MAX_WAIT  = (GATE_WAIT_CYCLES > SETTLE_CYCLES) ?
                                      GATE_WAIT_CYCLES : SETTLE_CYCLES;
  localparam int          CNT_WIDTH = $clog2(MAX_WAIT) + 1;

  localparam logic [CNT_WIDTH-1:0] GATE_LOAD   = CNT_WIDTH'(GATE_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

  switch_state_t state_q, state_n;
  logic          clk_sel_q, clk_sel_n;
  logic          clk_en_q, clk_en_n;
  logic          ack_q, ack_n;
  logic          busy_q, busy_n;
  logic          target_q, target_n;

  logic                 cnt_load;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;

  cluster_clock_switch_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      clk_sel_q <= RESET_SEL;
      clk_en_q  <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      target_q  <= RESET_SEL;
    end else begin
      state_q   <= state_n;
      clk_sel_q <= clk_sel_n;
      clk_en_q  <= clk_en_n;
      ack_q     <= ack_n;
      busy_q    <= busy_n;
      target_q  <= target_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    clk_sel_n    = clk_sel_q;
    clk_en_n     = clk_en_q;
    ack_n        = 1'b0;
    busy_n       = busy_q;
    target_n     = target_q;
    cnt_load     = 1'b0;
    cnt_load_val = GATE_LOAD;
    cnt_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Test mode freezes the select: requests are neither served nor acked.
        if (req_i && !test_mode_i) begin
          if (sel_target_i != clk_sel_q) begin
            clk_en_n     = 1'b0;
            busy_n       = 1'b1;
            target_n     = sel_target_i;
            cnt_load     = 1'b1;
            cnt_load_val = GATE_LOAD;
            state_n      = WAIT_OFF;
          end else begin
            ack_n = 1'b1;
          end
        end
      end
      WAIT_OFF: begin
        if (cnt_zero) begin
          clk_sel_n    = target_q;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
          state_n      = WAIT_SETTLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_SETTLE: begin
        if (cnt_zero) begin
          clk_en_n = 1'b1;
          ack_n    = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign clk_sel_o = clk_sel_q;
  assign clk_en_o  = clk_en_q | test_mode_i;
  assign ack_o     = ack_q;
  assign busy_o    = busy_q;

endmodule
